// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: mult/div occupancy tracking plus per-stage enable, clear and PC-select
// generation that merges hazard/mult-div stalls with M-stage exception and eret flushes.
module pipe_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hz_stall,
  input  logic       i_md_start_E,
  input  logic       i_md_is_div_E,
  input  logic       i_md_use_D,
  input  logic       i_exc_M,
  input  logic       i_eret_M,
  output logic       o_en_pc,
  output logic       o_en_D,
  output logic       o_clr_D,
  output logic       o_clr_E,
  output logic       o_clr_M,
  output logic       o_clr_W,
  output logic       o_md_go,
  output logic       o_md_busy,
  output logic [1:0] o_pc_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  // The start cycle is itself the first busy cycle, so the counter covers the remaining
  // N-1 cycles and the FSM returns to IDLE after the cycle in which it reads zero.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_md_go;
  logic w_md_busy;
  logic w_stall;
  logic w_flush;

  assign w_md_go   = ~i_reset & i_md_start_E & ~i_exc_M & (r_state == IDLE);
  assign w_md_busy = w_md_go | (r_state != IDLE);
  assign w_stall   = (i_md_use_D & w_md_busy) | i_hz_stall;
  assign w_flush   = i_exc_M | i_eret_M;

  // Flushes never abort a running operation: HI/LO updates are architectural.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_md_go) begin
            r_state <= i_md_is_div_E ? DIV : MULT;
            r_cnt   <= i_md_is_div_E ? DIV_LOAD : MULT_LOAD;
          end
        end
        MULT, DIV: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_en_pc   = 1'b1;
    o_en_D    = 1'b1;
    o_clr_D   = 1'b0;
    o_clr_E   = 1'b0;
    o_clr_M   = 1'b0;
    o_clr_W   = 1'b0;
    o_pc_sel  = 2'd0;
    o_md_go   = w_md_go;
    o_md_busy = w_md_busy;
    if (i_reset) begin
      o_clr_D = 1'b1;
      o_clr_E = 1'b1;
      o_clr_M = 1'b1;
      o_clr_W = 1'b1;
    end else if (w_flush) begin
      o_clr_D  = 1'b1;
      o_clr_E  = 1'b1;
      o_clr_M  = 1'b1;
      o_pc_sel = i_exc_M ? 2'd1 : 2'd2;
    end else begin
      o_en_pc = ~w_stall;
      o_en_D  = ~w_stall;
      o_clr_E = w_stall;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table with hand-computed outputs,
// followed by a hand-written back-to-back mult/div sequence.
module tb_pipe_ctrl;

  logic       clk;
  logic       reset, hz_stall, md_start_E, md_is_div_E, md_use_D, exc_M, eret_M;
  logic       en_pc, en_D, clr_D, clr_E, clr_M, clr_W, md_go, md_busy;
  logic [1:0] pc_sel;

  int errors = 0;
  int checks = 0;

  // Expected word layout: {en_pc,en_D,clr_D,clr_E,clr_M,clr_W,md_go,md_busy,pc_sel[1:0]}
  typedef struct {
    logic       rst, hz, st, dv, use_d, exc, eret;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];

  pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_hz_stall    (hz_stall),
    .i_md_start_E  (md_start_E),
    .i_md_is_div_E (md_is_div_E),
    .i_md_use_D    (md_use_D),
    .i_exc_M       (exc_M),
    .i_eret_M      (eret_M),
    .o_en_pc       (en_pc),
    .o_en_D        (en_D),
    .o_clr_D       (clr_D),
    .o_clr_E       (clr_E),
    .o_clr_M       (clr_M),
    .o_clr_W       (clr_W),
    .o_md_go       (md_go),
    .o_md_busy     (md_busy),
    .o_pc_sel      (pc_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, hz, st, dv, u, exc, eret, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.hz = hz; v.st = st; v.dv = dv; v.use_d = u; v.exc = exc; v.eret = eret;
    v.exp = exp;
    return v;
  endfunction

  // Drive inputs just after the falling edge and sample 2 time units later.
  task automatic drive(input logic rst, hz, st, dv, u, exc, eret);
    @(negedge clk);
    reset = rst; hz_stall = hz; md_start_E = st; md_is_div_E = dv;
    md_use_D = u; exc_M = exc; eret_M = eret;
    #2;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  function automatic logic [9:0] outs();
    return {en_pc, en_D, clr_D, clr_E, clr_M, clr_W, md_go, md_busy, pc_sel};
  endfunction

  initial begin
    int n;
    reset = 1'b1; hz_stall = 0; md_start_E = 0; md_is_div_E = 0;
    md_use_D = 0; exc_M = 0; eret_M = 0;

    // Reset (second cycle, with start/use asserted to show they are masked)
    vq.push_back(mk(1,0,1,0,1,0,0, 10'b1111110000));
    vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000000));
    // Mult started at t with a D-stage md user waiting: busy/stall t..t+4
    vq.push_back(mk(0,0,1,0,1,0,0, 10'b0001001100));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,1,0,0, 10'b0001000100));
    vq.push_back(mk(0,0,0,0,1,0,0, 10'b1100000000));
    // Div started at t, illegal start at t+3, busy t..t+9, idle at t+10
    vq.push_back(mk(0,0,1,1,1,0,0, 10'b0001001100));
    for (int i = 0; i < 2; i++) vq.push_back(mk(0,0,0,0,1,0,0, 10'b0001000100));
    vq.push_back(mk(0,0,1,1,1,0,0, 10'b0001000100));
    for (int i = 0; i < 6; i++) vq.push_back(mk(0,0,0,0,1,0,0, 10'b0001000100));
    vq.push_back(mk(0,0,0,0,1,0,0, 10'b1100000000));
    // Hazard stall together with exception: flush wins
    vq.push_back(mk(0,1,0,0,0,1,0, 10'b1111100001));
    vq.push_back(mk(0,1,0,0,0,0,0, 10'b0001000000));
    // Exception at t+2 of a div: not aborted
    vq.push_back(mk(0,0,1,1,0,0,0, 10'b1100001100));
    vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000100));
    vq.push_back(mk(0,0,0,0,0,1,0, 10'b1111100101));
    for (int i = 0; i < 6; i++) vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000100));
    vq.push_back(mk(0,0,0,0,1,0,0, 10'b0001000100));
    vq.push_back(mk(0,0,0,0,1,0,0, 10'b1100000000));
    // eret alone, then exc+eret together, then a start suppressed by exc
    vq.push_back(mk(0,0,0,0,0,0,1, 10'b1111100010));
    vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000000));
    vq.push_back(mk(0,0,0,0,0,1,1, 10'b1111100001));
    vq.push_back(mk(0,0,1,0,0,1,0, 10'b1111100001));
    vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000000));
    // Reset mid-mult: busy still visible in the reset cycle, idle afterwards
    vq.push_back(mk(0,0,1,0,0,0,0, 10'b1100001100));
    vq.push_back(mk(1,0,0,0,0,0,0, 10'b1111110100));
    vq.push_back(mk(0,0,0,0,0,0,0, 10'b1100000000));

    drive(1,0,0,0,0,0,0);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].hz, vq[i].st, vq[i].dv, vq[i].use_d, vq[i].exc, vq[i].eret);
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // Back-to-back: a new div may start in the cycle right after a mult's 5 busy cycles
    drive(0,0,1,0,0,0,0);
    check("seq_mult_go", {9'd0, md_go}, 10'd1);
    for (int k = 1; k < 5; k++) begin
      drive(0,0,0,0,0,0,0);
      check($sformatf("seq_mult_busy_%0d", k), {9'd0, md_busy}, 10'd1);
    end
    drive(0,0,1,1,0,0,0);
    check("seq_div_go", {9'd0, md_go}, 10'd1);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      drive(0,0,0,0,0,0,0);
      if (!md_busy) break;
      n++;
    end
    check("seq_div_busy_len", 10'(n), 10'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
